vram_write_scheduler: RTL and testbench

Buffers CPU-originated VRAM writes and commits them to the GPU's pattern, nametable, object and text memories only while the video timing reports the writable (vblank) window. Sits between the CPU bus decode and the GPU VRAM write port, replacing the unconditional `write_enable` path. Writes are committed strictly in arrival order, with a sticky overflow flag and a drain-complete pulse for software and debug.

---
 rtl/gpu_vram_pkg.sv | 32 +++
 rtl/vram_write_fifo.sv | 53 +++++
 rtl/vram_write_scheduler.sv | 154 +++++++++++++++
 tb/tb_vram_write_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_vram_pkg.sv
// Shared types for the VRAM write scheduler: commit targets, scheduler
// states and the queued write entry. The address width comes from the
// VRAM_ADDR_WIDTH macro (default 14 bits when the build does not set it).
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 14
`endif

package gpu_vram_pkg;

    localparam int VRAM_AW = `VRAM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        TGT_PMF  = 3'd0,
        TGT_PMB  = 3'd1,
        TGT_NTBL = 3'd2,
        TGT_OBM  = 3'd3,
        TGT_TXBL = 3'd4
    } vram_target_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [7:0]         data;
        vram_target_t       target;
    } vram_entry_t;

endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous FIFO holding pending VRAM writes. Pointers carry one extra
// MSB so full and empty are told apart; flush clears both pointers.
// Callers must not push when full or pop when empty.
module vram_write_fifo
    import gpu_vram_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = $bits(vram_entry_t)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointer update; flush takes priority over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[PW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/vram_write_scheduler.sv
// Queues CPU VRAM writes and commits them in order, one per cycle, only
// while video timing reports the writable window. Sticky overflow flags
// dropped requests; drain_done pulses when the queue empties mid-window.
// Optional feature: define VRAM_WRITE_BYPASS_EN to let a request arriving
// into an empty queue during the window go straight to the commit registers.
module vram_write_scheduler
    import gpu_vram_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH
) (
    input  logic                      gpu_clk,
    input  logic                      rst_n,
    input  logic                      writable,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [7:0]                wr_data,
    input  logic [2:0]                wr_target,
    input  logic                      flush,
    input  logic                      clr_overflow,
    output logic                      vram_we,
    output logic [ADDR_WIDTH-1:0]     vram_addr,
    output logic [7:0]                vram_data,
    output logic [2:0]                vram_target,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      drain_done
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(vram_entry_t);

    sched_state_t   state;
    sched_state_t   next_state;
    vram_entry_t    req_entry;
    vram_entry_t    head_entry;
    logic [EW-1:0]  head_bits;
    logic           fifo_full;
    logic           fifo_empty;
    logic [LW-1:0]  fifo_count;
    logic           accept;
    logic           drop;
    logic           bypass;
    logic           push;
    logic           pop;
    logic           done_next;
    logic           level_one;

    assign req_entry.addr   = wr_addr;
    assign req_entry.data   = wr_data;
    assign req_entry.target = vram_target_t'(wr_target);
    assign head_entry       = vram_entry_t'(head_bits);

    // Readiness depends only on occupancy; a same-cycle pop does not help.
    assign wr_ready  = !fifo_full;
    assign accept    = wr_valid && !fifo_full && !flush;
    assign drop      = wr_valid && fifo_full && !flush;
    assign level_one = (fifo_count == LW'(1));
    assign level     = fifo_count;

`ifdef VRAM_WRITE_BYPASS_EN
    assign bypass = accept && fifo_empty && writable &&
                    ((state == ST_IDLE) || (state == ST_DRAIN));
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;

    vram_write_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (gpu_clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (req_entry),
        .pop       (pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Scheduler state register.
    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state, pop and drain-complete decode; flush overrides everything.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (writable && !fifo_empty) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!writable || fifo_empty) begin
                    next_state = ST_IDLE;
                end else begin
                    pop = 1'b1;
                    // Last entry leaves and nothing arrives behind it.
                    if (level_one && !push) begin
                        next_state = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            ST_FLUSH: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (flush) begin
            next_state = ST_FLUSH;
            pop        = 1'b0;
            done_next  = 1'b0;
        end
    end

    // Commit registers: strobe follows pop/bypass, payload holds otherwise.
    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_we     <= 1'b0;
            vram_addr   <= '0;
            vram_data   <= '0;
            vram_target <= '0;
            drain_done  <= 1'b0;
        end else begin
            vram_we    <= pop || bypass;
            drain_done <= done_next;
            if (pop) begin
                vram_addr   <= head_entry.addr;
                vram_data   <= head_entry.data;
                vram_target <= head_entry.target;
            end else if (bypass) begin
                vram_addr   <= wr_addr;
                vram_data   <= wr_data;
                vram_target <= wr_target;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle beats the clear.
    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n)            overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Bench for vram_write_scheduler: a vector table for the basic
// queue-then-drain sequence, hand-written corner sequences, then a long
// randomized run against a queue-based reference model.
module tb_vram_write_scheduler;
    import gpu_vram_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = VRAM_AW;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          gpu_clk;
    logic          rst_n;
    logic          writable;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [2:0]    wr_target;
    logic          flush;
    logic          clr_overflow;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_data;
    logic [2:0]    vram_target;
    logic [LW-1:0] level;
    logic          overflow;
    logic          drain_done;

    int n_cmp = 0;
    int n_bad = 0;

    vram_write_scheduler #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .gpu_clk      (gpu_clk),
        .rst_n        (rst_n),
        .writable     (writable),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_target    (wr_target),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_data    (vram_data),
        .vram_target  (vram_target),
        .level        (level),
        .overflow     (overflow),
        .drain_done   (drain_done)
    );

    initial gpu_clk = 1'b0;
    always #5 gpu_clk = ~gpu_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          w;
        logic          v;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [2:0]    t;
        logic          e_we;
        logic [AW-1:0] e_a;
        logic [7:0]    e_d;
        logic [2:0]    e_t;
        int            e_lvl;
        logic          e_dd;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [2:0]    t;
    } ent_t;

    vec_t tbl[10];

    ent_t mq[$];
    ent_t m_last;
    ent_t req;
    bit   m_drain, m_flushing, m_ovf, m_we, m_dd;
    bit   m_pop, m_byp, m_acc, m_drop;
    int   sz;

    function automatic vec_t mk(logic w, logic v, logic [AW-1:0] a, logic [7:0] d,
                                logic [2:0] t, logic e_we, logic [AW-1:0] e_a,
                                logic [7:0] e_d, logic [2:0] e_t, int e_lvl, logic e_dd);
        vec_t r;
        r.w = w; r.v = v; r.a = a; r.d = d; r.t = t;
        r.e_we = e_we; r.e_a = e_a; r.e_d = e_d; r.e_t = e_t;
        r.e_lvl = e_lvl; r.e_dd = e_dd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic we, input logic [AW-1:0] a,
                           input logic [7:0] d, input logic [2:0] t, input int lvl,
                           input logic ovf, input logic dd, input logic rdy);
        chk({tag, ".we"},    32'(vram_we),     32'(we));
        chk({tag, ".addr"},  32'(vram_addr),   32'(a));
        chk({tag, ".data"},  32'(vram_data),   32'(d));
        chk({tag, ".tgt"},   32'(vram_target), 32'(t));
        chk({tag, ".level"}, 32'(level),       32'(lvl));
        chk({tag, ".ovf"},   32'(overflow),    32'(ovf));
        chk({tag, ".dd"},    32'(drain_done),  32'(dd));
        chk({tag, ".ready"}, 32'(wr_ready),    32'(rdy));
    endtask

    task automatic tick();
        @(posedge gpu_clk);
        #1;
    endtask

    task automatic push_req(input logic [AW-1:0] a, input logic [7:0] d, input logic [2:0] t);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_target = t;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; writable = 1'b0; wr_valid = 1'b0; wr_addr = '0;
        wr_data = '0; wr_target = '0; flush = 1'b0; clr_overflow = 1'b0;
        tick(); tick();
        chk_all("reset", 1'b0, '0, 8'h00, 3'd0, 0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick();

        // Queue three writes outside the window, then drain them.
        tbl[0] = mk(0, 1, 'h010, 8'hAA, TGT_PMF,  0, 'h000, 8'h00, 3'd0, 1, 0);
        tbl[1] = mk(0, 1, 'h011, 8'hBB, TGT_NTBL, 0, 'h000, 8'h00, 3'd0, 2, 0);
        tbl[2] = mk(0, 1, 'h7FF, 8'hCC, TGT_TXBL, 0, 'h000, 8'h00, 3'd0, 3, 0);
        tbl[3] = mk(0, 0, 'h000, 8'h00, 3'd0,     0, 'h000, 8'h00, 3'd0, 3, 0);
        tbl[4] = mk(1, 0, 'h000, 8'h00, 3'd0,     0, 'h000, 8'h00, 3'd0, 3, 0);
        tbl[5] = mk(1, 0, 'h000, 8'h00, 3'd0,     1, 'h010, 8'hAA, TGT_PMF,  2, 0);
        tbl[6] = mk(1, 0, 'h000, 8'h00, 3'd0,     1, 'h011, 8'hBB, TGT_NTBL, 1, 0);
        tbl[7] = mk(1, 0, 'h000, 8'h00, 3'd0,     1, 'h7FF, 8'hCC, TGT_TXBL, 0, 1);
        tbl[8] = mk(1, 0, 'h000, 8'h00, 3'd0,     0, 'h7FF, 8'hCC, TGT_TXBL, 0, 0);
        tbl[9] = mk(0, 0, 'h000, 8'h00, 3'd0,     0, 'h7FF, 8'hCC, TGT_TXBL, 0, 0);
        for (int i = 0; i < 10; i++) begin
            writable = tbl[i].w; wr_valid = tbl[i].v; wr_addr = tbl[i].a;
            wr_data = tbl[i].d; wr_target = tbl[i].t;
            tick();
            chk_all($sformatf("tbl%0d", i), tbl[i].e_we, tbl[i].e_a, tbl[i].e_d,
                    tbl[i].e_t, tbl[i].e_lvl, 1'b0, tbl[i].e_dd, 1'b1);
        end
        wr_valid = 1'b0; writable = 1'b0;

        // Overflow: 17 requests into 16 entries.
        for (int i = 0; i < 16; i++) push_req(AW'(i), 8'(i), 3'd1);
        chk("ovf.level16", 32'(level), 32'd16);
        chk("ovf.ready_full", 32'(wr_ready), 32'd0);
        chk("ovf.before", 32'(overflow), 32'd0);
        push_req('h3FF, 8'hEE, 3'd1);
        chk("ovf.set", 32'(overflow), 32'd1);
        chk("ovf.level_after", 32'(level), 32'd16);
        clr_overflow = 1'b1; wr_valid = 1'b1;
        tick();
        chk("ovf.set_wins", 32'(overflow), 32'd1);
        wr_valid = 1'b0;
        tick();
        chk("ovf.cleared", 32'(overflow), 32'd0);
        clr_overflow = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0; tick();
        chk("ovf.flushed", 32'(level), 32'd0);

        // Window closes after four commits; the rest go in the next window.
        for (int i = 0; i < 10; i++) push_req(AW'('h100 + i), 8'(8'h40 + i), 3'(i % 5));
        writable = 1'b1;
        tick();
        chk("mid.enter_we", 32'(vram_we), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mid.we%0d", k), 32'(vram_we), 32'd1);
            chk($sformatf("mid.data%0d", k), 32'(vram_data), 32'(8'h40 + k));
            chk($sformatf("mid.dd%0d", k), 32'(drain_done), 32'd0);
        end
        writable = 1'b0;
        tick();
        chk("mid.closed_we", 32'(vram_we), 32'd0);
        chk("mid.level6", 32'(level), 32'd6);
        chk("mid.no_dd", 32'(drain_done), 32'd0);
        tick();
        writable = 1'b1;
        tick();
        for (int k = 4; k < 10; k++) begin
            tick();
            chk($sformatf("mid2.we%0d", k), 32'(vram_we), 32'd1);
            chk($sformatf("mid2.addr%0d", k), 32'(vram_addr), 32'('h100 + k));
            chk($sformatf("mid2.dd%0d", k), 32'(drain_done), 32'(k == 9));
        end
        chk("mid2.level0", 32'(level), 32'd0);
        writable = 1'b0;
        tick();

        // Flush with a simultaneous request: nothing is kept, no overflow.
        for (int i = 0; i < 5; i++) push_req(AW'('h200 + i), 8'(i), 3'd2);
        flush = 1'b1; wr_valid = 1'b1; wr_addr = 'h2FF;
        tick();
        flush = 1'b0; wr_valid = 1'b0;
        chk("flush.level", 32'(level), 32'd0);
        chk("flush.ovf", 32'(overflow), 32'd0);
        chk("flush.we", 32'(vram_we), 32'd0);
        writable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("flush.nocommit%0d", k), 32'(vram_we), 32'd0);
        end
        writable = 1'b0;
        tick();

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 6; i++) push_req(AW'('h300 + i), 8'(8'h60 + i), 3'd3);
        writable = 1'b1;
        tick();
        tick();
        chk("arst.draining", 32'(vram_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("arst", 1'b0, '0, 8'h00, 3'd0, 0, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("arst.after_we%0d", k), 32'(vram_we), 32'd0);
            chk($sformatf("arst.after_lvl%0d", k), 32'(level), 32'd0);
        end

`ifdef VRAM_WRITE_BYPASS_EN
        // Empty queue inside the window: the request skips the queue.
        wr_valid = 1'b1; wr_addr = 'h123; wr_data = 8'h5A; wr_target = TGT_OBM;
        tick();
        wr_valid = 1'b0;
        chk("byp.we", 32'(vram_we), 32'd1);
        chk("byp.addr", 32'(vram_addr), 32'h123);
        chk("byp.data", 32'(vram_data), 32'h5A);
        chk("byp.tgt", 32'(vram_target), 32'(TGT_OBM));
        chk("byp.level", 32'(level), 32'd0);
        tick();
        chk("byp.we_off", 32'(vram_we), 32'd0);
`endif

        // Clean start for the randomized run.
        writable = 1'b0;
        rst_n = 1'b0; #2 rst_n = 1'b1;
        mq.delete(); m_last = '0; m_drain = 0; m_flushing = 0; m_ovf = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 11) == 0) writable = !writable;
            wr_valid     = ($urandom_range(0, 9) < 6);
            wr_addr      = AW'($urandom);
            wr_data      = 8'($urandom);
            wr_target    = 3'($urandom_range(0, 4));
            flush        = ($urandom_range(0, 63) == 0);
            clr_overflow = ($urandom_range(0, 31) == 0);
            req.a = wr_addr; req.d = wr_data; req.t = wr_target;

            sz     = mq.size();
            m_acc  = wr_valid && !flush && (sz < DEPTH);
            m_drop = wr_valid && !flush && (sz == DEPTH);
            m_pop  = 0; m_byp = 0; m_we = 0; m_dd = 0;
            if (flush) begin
                mq.delete();
                m_drain = 0;
                m_flushing = 1;
            end else begin
                m_pop = m_drain && writable && (sz > 0);
`ifdef VRAM_WRITE_BYPASS_EN
                m_byp = m_acc && (sz == 0) && writable && !m_flushing;
`endif
                if (m_pop) begin
                    m_last = mq.pop_front();
                    m_we = 1;
                end else if (m_byp) begin
                    m_last = req;
                    m_we = 1;
                end
                if (m_acc && !m_byp) mq.push_back(req);
                if (m_flushing) begin
                    m_flushing = 0;
                    m_drain = 0;
                end else if (m_drain) begin
                    m_dd    = m_pop && (mq.size() == 0);
                    m_drain = writable && (sz > 0) && (mq.size() > 0);
                end else begin
                    m_drain = writable && (sz > 0);
                end
            end
            if (m_drop) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;

            tick();
            chk_all($sformatf("rnd%0d", cyc), m_we, m_last.a, m_last.d, m_last.t,
                    mq.size(), m_ovf, m_dd, (mq.size() < DEPTH));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
